// File: rtl/inst_feed_pkg.sv
// -----------------------------------------------------------------------------
// inst_feed_pkg
// Shared definitions for the instruction feed stage:
//   feed_state_e : fetch FSM states (IDLE, WAIT, STALL)
//   SPARC_NOP    : SPARC "nop" encoding (sethi 0, %g0)
//   cnt_width()  : width of an occupancy counter able to hold 0..depth
// -----------------------------------------------------------------------------
package inst_feed_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STALL
    } feed_state_e;

    localparam logic [31:0] SPARC_NOP = 32'h0100_0000;

    // Occupancy must represent DEPTH itself, hence one bit beyond the pointer.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/inst_feed_stage_fifo.sv
// -----------------------------------------------------------------------------
// inst_fifo
// Synchronous FIFO with occupancy count and no fall-through: a word written in
// a cycle becomes readable only from the next cycle on.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   flush_i       : empty the FIFO; a push in the same cycle is dropped
//   push_i        : write wdata_i (ignored when full)
//   pop_i         : advance the read pointer (ignored when empty)
//   wdata_i       : write data
//   rdata_o       : head word (valid when !empty_o)
//   full_o        : count == DEPTH
//   empty_o       : count == 0
//   count_o       : current occupancy
// -----------------------------------------------------------------------------
module inst_fifo
    import inst_feed_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [WIDTH-1:0]              wdata_i,
    output logic [WIDTH-1:0]              rdata_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [cnt_width(DEPTH)-1:0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Full/empty come straight from the registered count, so a pop cannot
    // open a slot for a push in the same cycle.
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            // Pointers are DEPTH-sized (power of two) and wrap naturally.
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/inst_feed_stage.sv
// -----------------------------------------------------------------------------
// inst_feed_stage
// Instruction supply for the integer unit's icache port. Words pushed by the
// driver are queued and handed out one per core fetch, with optional wait
// states, bounded stalling on an empty queue and NOP substitution.
//   clk, rst        : clock, synchronous active-high reset
//   push_valid/data : driver word offer; accepted when push_ready
//   push_ready      : !full
//   fetch_en        : core requests the next instruction
//   fetch_null      : annul the current fetch (answer NOP, no pop)
//   flush           : discard queue and any pending fetch
//   ic_data         : instruction to the core
//   ic_hold         : active-low stall to the core
//   ic_mds          : one-cycle strobe when data arrives after a hold
//   ic_exception    : always 0
//   fifo_count      : queue occupancy
//   underflow_cnt   : saturating count of timeout NOP substitutions
// -----------------------------------------------------------------------------
module inst_feed_stage
    import inst_feed_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned STALL_LIMIT = 8,
    parameter logic [31:0] NOP_WORD    = SPARC_NOP
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_valid,
    input  logic [31:0]                 push_data,
    output logic                        push_ready,
    input  logic                        fetch_en,
    input  logic                        fetch_null,
    input  logic                        flush,
    output logic [31:0]                 ic_data,
    output logic                        ic_hold,
    output logic                        ic_mds,
    output logic                        ic_exception,
    output logic [cnt_width(DEPTH)-1:0] fifo_count,
    output logic [15:0]                 underflow_cnt
);

    feed_state_e state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [7:0]  stall_q, stall_d;
    logic [31:0] data_q, data_d;
    logic        hold_q, hold_d;
    logic        mds_q, mds_d;
    logic [15:0] ufl_q, ufl_d;

    logic        pop;
    logic        fifo_full, fifo_empty;
    logic [31:0] fifo_rdata;

    inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .push_i  (push_valid),
        .pop_i   (pop),
        .wdata_i (push_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        stall_d = stall_q;
        data_d  = data_q;
        hold_d  = hold_q;
        mds_d   = 1'b0;
        ufl_d   = ufl_q;
        pop     = 1'b0;

        if (flush) begin
            state_d = IDLE;
            data_d  = NOP_WORD;
            hold_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_en) begin
                        if (fetch_null) begin
                            data_d = NOP_WORD;
                        end else if (WAIT_STATES != 0) begin
                            state_d = WAIT;
                            hold_d  = 1'b0;
                            wait_d  = 4'(WAIT_STATES - 1);
                        end else if (!fifo_empty) begin
                            pop    = 1'b1;
                            data_d = fifo_rdata;
                        end else begin
                            state_d = STALL;
                            hold_d  = 1'b0;
                            stall_d = '0;
                        end
                    end
                end
                WAIT: begin
                    if (wait_q != '0) begin
                        wait_d = wait_q - 1'b1;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        data_d  = fifo_rdata;
                        hold_d  = 1'b1;
                        mds_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = STALL;
                        stall_d = '0;
                    end
                end
                STALL: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        data_d  = fifo_rdata;
                        hold_d  = 1'b1;
                        mds_d   = 1'b1;
                        state_d = IDLE;
                    end else if (stall_q == 8'(STALL_LIMIT - 1)) begin
                        data_d  = NOP_WORD;
                        hold_d  = 1'b1;
                        mds_d   = 1'b1;
                        state_d = IDLE;
                        if (ufl_q != '1) ufl_d = ufl_q + 1'b1;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wait_q  <= '0;
            stall_q <= '0;
            data_q  <= NOP_WORD;
            hold_q  <= 1'b1;
            mds_q   <= 1'b0;
            ufl_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
            mds_q   <= mds_d;
            ufl_q   <= ufl_d;
        end
    end

    assign ic_data       = data_q;
    assign ic_hold       = hold_q;
    assign ic_mds        = mds_q;
    assign ic_exception  = 1'b0;
    assign push_ready    = !fifo_full;
    assign underflow_cnt = ufl_q;

endmodule
